serial_addsub: RTL and testbench



---
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_addsub.sv | 110 +++++++++++
 tb/tb_serial_addsub.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - request/result bundle for the bit-serial adder/subtractor
interface serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry, overflow, zero
    );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial add/sub, one bit per clock LSB first; SERIAL_ADDSUB_FLAGS_EN enables overflow/zero
module serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [CW-1:0]    count;
    logic             c;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;

    logic             sum_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_next;

    assign sum_bit  = a_sr[0] ^ b_sr[0] ^ c;
    assign c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign res_next = {sum_bit, res_sr};

`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic overflow_r;
    logic zero_r;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            count   <= '0;
            c       <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            carry_r <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
                        a_sr   <= bus.a;
                        b_sr   <= bus.sub ? ~bus.b : bus.b;
                        c      <= bus.sub;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next[WIDTH-1:1];
                    c      <= c_next;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        sum_r   <= res_next;
                        carry_r <= c_next;
`ifdef SERIAL_ADDSUB_FLAGS_EN
                        // c still holds the carry into the MSB at this edge.
                        overflow_r <= c ^ c_next;
                        zero_r     <= (res_next == '0);
`endif
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.sum   = sum_r;
    assign bus.carry = carry_r;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    assign bus.overflow = overflow_r;
    assign bus.zero     = zero_r;
`else
    assign bus.overflow = 1'b0;
    assign bus.zero     = 1'b0;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - vector table, corner sequences and random ops against an arithmetic model
module tb_serial_addsub;
    localparam int WIDTH = 16;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                  output logic [15:0] s, output logic c, output logic ov,
                                  output logic z);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ur = ms ? (ua - ub) : (ua + ub);
        sr = ms ? (sa - sb) : (sa + sb);
        s  = ur[15:0];
        c  = ms ? (ua >= ub) : (ur > 65535);
        ov = FLAGS_EN && (sr > 32767 || sr < -32768);
        z  = FLAGS_EN && (s == 16'h0000);
    endfunction

    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts);
        @(negedge clk);
        bus.a = ta;
        bus.b = tb_v;
        bus.sub = ts;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.sub = 1'($urandom);
    endtask

    task automatic finish_op(input string name, input logic [15:0] es, input logic ec,
                             input logic eo, input logic ez, input int inject);
        logic [15:0] pre;
        bit          stable;
        int          lat;
        @(negedge clk);
        check({name, " busy_after_start"}, 32'(bus.busy), 32'd1);
        check({name, " done_low_after_start"}, 32'(bus.done), 32'd0);
        pre = bus.sum;
        stable = 1'b1;
        lat = -1;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            @(negedge clk);
            if (inject != 0 && k == inject) begin
                bus.start = 1'b1;
                bus.a = 16'hAAAA;
                bus.b = 16'h5555;
                bus.sub = 1'b0;
            end
            if (inject != 0 && k == inject + 1) bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.sum !== pre || bus.busy !== 1'b1) stable = 1'b0;
        end
        check({name, " latency"}, 32'(lat), 32'(WIDTH));
        check({name, " stable_while_busy"}, 32'(stable), 32'd1);
        check({name, " busy_at_done"}, 32'(bus.busy), 32'd0);
        check({name, " sum"}, 32'(bus.sum), 32'(es));
        check({name, " carry"}, 32'(bus.carry), 32'(ec));
        check({name, " overflow"}, 32'(bus.overflow), 32'(eo));
        check({name, " zero"}, 32'(bus.zero), 32'(ez));
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"}, 32'(bus.busy), 32'd0);
        check({name, " done"}, 32'(bus.done), 32'd0);
        check({name, " sum"}, 32'(bus.sum), 32'd0);
        check({name, " carry"}, 32'(bus.carry), 32'd0);
        check({name, " overflow"}, 32'(bus.overflow), 32'd0);
        check({name, " zero"}, 32'(bus.zero), 32'd0);
    endtask

    initial begin
        logic [15:0] ms, ra, rb;
        logic        mc, mo, mz, rs;
        int          ndone;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            finish_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].carry,
                      vecs[i].ovf & FLAGS_EN, vecs[i].zero & FLAGS_EN, 0);
        end

        // Start pulsed mid-operation must be ignored, with no extra done afterwards.
        start_op(16'h1234, 16'h4321, 1'b0);
        finish_op("ignored_start", 16'h5555, 1'b0, 1'b0, 1'b0, 5);
        ndone = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("ignored_start extra_done", 32'(ndone), 32'd0);

        // Back-to-back: new start during the DONE cycle.
        start_op(16'h1234, 16'h4321, 1'b0);
        finish_op("b2b_first", 16'h5555, 1'b0, 1'b0, 1'b0, 0);
        bus.a = 16'h0002;
        bus.b = 16'h0003;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        check("b2b done_in_done_cycle", 32'(bus.done), 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        finish_op("b2b_second", 16'h0005, 1'b0, 1'b0, 1'b0, 0);

        // Asynchronous reset mid-SHIFT after a result with nonzero sum and carry.
        start_op(16'h8000, 16'h8001, 1'b0);
        finish_op("pre_reset", 16'h0001, 1'b1, FLAGS_EN, 1'b0, 0);
        start_op(16'hF0F0, 16'h0F0F, 1'b0);
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        start_op(16'h0001, 16'h0001, 1'b0);
        finish_op("post_reset", 16'h0002, 1'b0, 1'b0, 1'b0, 0);

        for (int n = 0; n < 30; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (n % 6 == 1) rb = ra;
            if (n % 6 == 2) ra = 16'h7FFF;
            if (n % 6 == 3) ra = 16'h8000;
            model(ra, rb, rs, ms, mc, mo, mz);
            start_op(ra, rb, rs);
            finish_op($sformatf("rand%0d a=%h b=%h sub=%0d", n, ra, rb, rs), ms, mc, mo, mz, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
